// File: rtl/fetch_byte_queue_pkg.sv
// Shared sizes and byte-order types for the fetch byte queue.
// Byte i of a line or window sits at [W-1-8*i -: 8], i.e. byte 0 is the MSB byte.
package fetch_byte_queue_pkg;

  localparam int LINE_BYTES = 16;
  localparam int WIN_BYTES  = 32;
  localparam int LINE_W     = LINE_BYTES * 8;
  localparam int WIN_W      = WIN_BYTES * 8;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [WIN_W-1:0]  win_t;

endpackage

// File: rtl/fetch_byte_queue_byte_window_shift.sv
// Combinational window update: drop rd_i leading bytes, then insert line bytes
// skip_i..15 at byte position pos_i.
module byte_window_shift
  import fetch_byte_queue_pkg::*;
(
  input  win_t        win_i,
  input  logic [5:0]  rd_i,
  input  logic [5:0]  pos_i,
  input  line_t       line_i,
  input  logic [3:0]  skip_i,
  input  logic        app_i,
  output win_t        win_o
);

  logic [8:0] rd_sh;
  logic [8:0] pos_sh;
  logic [6:0] skip_sh;
  win_t       shifted;
  win_t       inserted;

  // Bytes past the valid count are always zero, so OR-ing the insert is safe.
  always_comb begin
    rd_sh    = {rd_i, 3'b000};
    pos_sh   = {pos_i, 3'b000};
    skip_sh  = {skip_i, 3'b000};
    shifted  = win_i << rd_sh;
    inserted = '0;
    if (app_i) begin
      inserted = {line_i << skip_sh, {LINE_W{1'b0}}} >> pos_sh;
    end
    win_o = shifted | inserted;
  end

endmodule

// File: rtl/fetch_byte_queue.sv
// Fetch stage: streams 16-byte cache lines into a 32-byte window for the decoder,
// with credit-based request issue and redirect handling that drops in-flight lines.
module fetch_byte_queue
  import fetch_byte_queue_pkg::*;
#(
  parameter int                IADDRW   = 32,
  parameter logic [IADDRW-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_eip,
  input  logic [IADDRW-1:0] eip,
  output logic              ic_req_valid,
  input  logic              ic_req_ready,
  output logic [IADDRW-1:0] ic_req_addr,
  input  logic              ic_resp_valid,
  input  logic [127:0]      ic_resp_data,
  output logic              f_valid,
  input  logic              f_ready,
  input  logic [5:0]        f_bytes_read,
  output logic [5:0]        f_valid_bytes,
  output logic [255:0]      f_instruction,
  output logic [IADDRW-1:0] f_pc,
  output logic              f_branch_taken
);

  win_t              win_q, win_d, win_upd;
  logic [5:0]        count_q, count_d;
  logic [IADDRW-1:0] fetch_addr_q, fetch_addr_d;
  logic [IADDRW-1:0] pc_q, pc_d;
  logic [1:0]        outstanding_q, outstanding_d;
  logic [1:0]        drop_q, drop_d;
  logic [3:0]        skip_q, skip_d;

  logic       consume;
  logic [5:0] rd;
  logic       app;
  logic [5:0] app_len;
  logic [5:0] pos;
  logic [7:0] credit_need;
  logic [7:0] credit_avail;
  logic       req_fire;

  // The redirect cycle never issues, so no untracked response can follow it.
  always_comb begin
    consume      = (count_q != 6'd0) && f_ready;
    rd           = consume ? f_bytes_read : 6'd0;
    app          = ic_resp_valid && (drop_q == 2'd0);
    app_len      = 6'(LINE_BYTES) - {2'b00, skip_q};
    pos          = count_q - rd;
    credit_need  = 8'(count_q) + (8'(outstanding_q) + 8'd1) * 8'(LINE_BYTES);
    credit_avail = 8'(WIN_BYTES) + 8'(rd);
    ic_req_valid = reset && !write_eip && (credit_need <= credit_avail);
    req_fire     = ic_req_valid && ic_req_ready;
  end

  byte_window_shift u_shift (
    .win_i  (win_q),
    .rd_i   (rd),
    .pos_i  (pos),
    .line_i (ic_resp_data),
    .skip_i (skip_q),
    .app_i  (app),
    .win_o  (win_upd)
  );

  always_comb begin
    win_d         = win_q;
    count_d       = count_q;
    fetch_addr_d  = fetch_addr_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    skip_d        = skip_q;
    if (write_eip) begin
      win_d         = '0;
      count_d       = 6'd0;
      pc_d          = eip;
      fetch_addr_d  = {eip[IADDRW-1:4], 4'b0000};
      skip_d        = eip[3:0];
      outstanding_d = outstanding_q - {1'b0, ic_resp_valid};
      drop_d        = outstanding_q - {1'b0, ic_resp_valid};
    end else begin
      win_d         = win_upd;
      count_d       = count_q - rd + (app ? app_len : 6'd0);
      pc_d          = pc_q + {{(IADDRW-6){1'b0}}, rd};
      outstanding_d = outstanding_q + {1'b0, req_fire} - {1'b0, ic_resp_valid};
      if (req_fire) begin
        fetch_addr_d = fetch_addr_q + IADDRW'(LINE_BYTES);
      end
      if (ic_resp_valid && (drop_q != 2'd0)) begin
        drop_d = drop_q - 2'd1;
      end
      if (app) begin
        skip_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q         <= '0;
      count_q       <= 6'd0;
      fetch_addr_q  <= {RESET_PC[IADDRW-1:4], 4'b0000};
      pc_q          <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_q        <= 2'd0;
      skip_q        <= RESET_PC[3:0];
    end else begin
      win_q         <= win_d;
      count_q       <= count_d;
      fetch_addr_q  <= fetch_addr_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      skip_q        <= skip_d;
    end
  end

  assign ic_req_addr    = fetch_addr_q;
  assign f_valid        = (count_q != 6'd0);
  assign f_valid_bytes  = count_q;
  assign f_instruction  = win_q;
  assign f_pc           = pc_q;
  assign f_branch_taken = 1'b0;

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Self-checking bench for fetch_byte_queue: in-order cache model with variable
// latency, byte-stream scoreboard checked every cycle, and scenario tasks.
module tb_fetch_byte_queue;

  logic         clk;
  logic         reset;
  logic         write_eip;
  logic [31:0]  eip;
  logic         ic_req_valid;
  logic         ic_req_ready;
  logic [31:0]  ic_req_addr;
  logic         ic_resp_valid;
  logic [127:0] ic_resp_data;
  logic         f_valid;
  logic         f_ready;
  logic [5:0]   f_bytes_read;
  logic [5:0]   f_valid_bytes;
  logic [255:0] f_instruction;
  logic [31:0]  f_pc;
  logic         f_branch_taken;

  int vectors     = 0;
  int miscompares = 0;
  int consumed    = 0;
  int cyc         = 0;
  int lat         = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } exp_t;

  req_t         pend[$];
  exp_t         exp_q[$];
  logic [31:0]  exp_tail;
  logic [255:0] exp_win;

  fetch_byte_queue #(
    .IADDRW   (32),
    .RESET_PC (32'h0000_0100)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .write_eip      (write_eip),
    .eip            (eip),
    .ic_req_valid   (ic_req_valid),
    .ic_req_ready   (ic_req_ready),
    .ic_req_addr    (ic_req_addr),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_data   (ic_resp_data),
    .f_valid        (f_valid),
    .f_ready        (f_ready),
    .f_bytes_read   (f_bytes_read),
    .f_valid_bytes  (f_valid_bytes),
    .f_instruction  (f_instruction),
    .f_pc           (f_pc),
    .f_branch_taken (f_branch_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[127-8*k -: 8] = mem_byte(a + 32'(k));
    return d;
  endfunction

  task automatic refill();
    exp_t e;
    while (exp_q.size() < 64) begin
      e.addr = exp_tail;
      e.data = mem_byte(exp_tail);
      exp_q.push_back(e);
      exp_tail = exp_tail + 32'd1;
    end
  endtask

  task automatic start_stream(input logic [31:0] a);
    exp_q.delete();
    exp_tail = a;
    refill();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // In-order cache: accepts on handshake, answers after lat cycles, one per cycle.
  always @(posedge clk) begin
    req_t r;
    if (!reset) begin
      pend.delete();
    end else begin
      if (ic_resp_valid) pend.delete(0);
      if (ic_req_valid && ic_req_ready) begin
        r.addr = ic_req_addr;
        r.due  = cyc + lat;
        pend.push_back(r);
      end
    end
    cyc++;
    #1;
    if (reset && pend.size() > 0 && pend[0].due <= cyc) begin
      ic_resp_valid = 1'b1;
      ic_resp_data  = line_of(pend[0].addr);
    end else begin
      ic_resp_valid = 1'b0;
      ic_resp_data  = '0;
    end
  end

  // Scoreboard: the window must always be a prefix of the program byte stream.
  always @(negedge clk) begin
    if (reset && !write_eip) begin
      exp_win = '0;
      for (int i = 0; i < 32; i++) begin
        if (i < int'(f_valid_bytes)) exp_win[255-8*i -: 8] = exp_q[i].data;
      end
      vectors++;
      if (f_instruction !== exp_win || f_pc !== exp_q[0].addr ||
          f_valid !== (f_valid_bytes != 6'd0) || f_valid_bytes > 6'd32) begin
        miscompares++;
        $display("[TB] FAIL window: pc=%h n=%0d win=%h expected pc=%h win=%h",
                 f_pc, f_valid_bytes, f_instruction, exp_q[0].addr, exp_win);
      end
      if (f_valid && f_ready) begin
        for (int i = 0; i < int'(f_bytes_read); i++) exp_q.delete(0);
        consumed += int'(f_bytes_read);
        refill();
      end
    end
  end

  always @(posedge clk) begin
    if (reset && f_valid && f_ready && !write_eip) begin
      assert (f_bytes_read != 6'd0 && f_bytes_read <= f_valid_bytes)
        else $error("[TB] illegal consume of %0d with %0d valid", f_bytes_read, f_valid_bytes);
    end
  end

  task automatic test_reset();
    tick();
    tick();
    vectors++;
    if (f_valid !== 1'b0 || f_valid_bytes !== 6'd0 || f_instruction !== '0 ||
        ic_req_valid !== 1'b0 || f_branch_taken !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: valid=%b n=%0d req=%b bt=%b expected all 0",
               f_valid, f_valid_bytes, ic_req_valid, f_branch_taken);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h100) begin
      miscompares++;
      $display("[TB] FAIL first_req: valid=%b addr=%h expected 1 00000100", ic_req_valid, ic_req_addr);
    end
    tick();
    #1;
    vectors++;
    if (f_valid_bytes !== 6'd0 || ic_req_valid !== 1'b1 || ic_req_addr !== 32'h110) begin
      miscompares++;
      $display("[TB] FAIL second_req: n=%0d valid=%b addr=%h expected 0 1 00000110",
               f_valid_bytes, ic_req_valid, ic_req_addr);
    end
    tick();
    vectors++;
    if (f_valid_bytes !== 6'd16 || f_pc !== 32'h100 || f_instruction[255:248] !== mem_byte(32'h100)) begin
      miscompares++;
      $display("[TB] FAIL first_line: n=%0d pc=%h b0=%h expected 16 00000100 %h",
               f_valid_bytes, f_pc, f_instruction[255:248], mem_byte(32'h100));
    end
    tick();
    #1;
    vectors++;
    if (f_valid_bytes !== 6'd32 || ic_req_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL window_full: n=%0d req=%b expected 32 0", f_valid_bytes, ic_req_valid);
    end
  endtask

  task automatic test_consume();
    f_ready = 1'b1;
    f_bytes_read = 6'd3;
    #1;
    vectors++;
    if (ic_req_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL credit_withheld: req=%b expected 0", ic_req_valid);
    end
    tick();
    vectors++;
    if (f_valid_bytes !== 6'd29 || f_pc !== 32'h103 || f_instruction[255:248] !== mem_byte(32'h103)) begin
      miscompares++;
      $display("[TB] FAIL consume3: n=%0d pc=%h b0=%h expected 29 00000103 %h",
               f_valid_bytes, f_pc, f_instruction[255:248], mem_byte(32'h103));
    end
    f_bytes_read = 6'd16;
    #1;
    vectors++;
    if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h120) begin
      miscompares++;
      $display("[TB] FAIL credit_granted: req=%b addr=%h expected 1 00000120", ic_req_valid, ic_req_addr);
    end
    tick();
    vectors++;
    if (f_valid_bytes !== 6'd13 || f_pc !== 32'h113) begin
      miscompares++;
      $display("[TB] FAIL consume16: n=%0d pc=%h expected 13 00000113", f_valid_bytes, f_pc);
    end
    f_bytes_read = 6'd5;
    tick();
    f_ready = 1'b0;
    #1;
    vectors++;
    if (f_valid_bytes !== 6'd24 || f_pc !== 32'h118 || f_instruction[255:248] !== mem_byte(32'h118) ||
        f_instruction[191:184] !== mem_byte(32'h120) || ic_req_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL shift_then_append: n=%0d pc=%h b0=%h b8=%h req=%b expected 24 00000118 %h %h 0",
               f_valid_bytes, f_pc, f_instruction[255:248], f_instruction[191:184], ic_req_valid,
               mem_byte(32'h118), mem_byte(32'h120));
    end
  endtask

  task automatic test_redirect_drop();
    lat = 3;
    tick();
    write_eip = 1'b1;
    eip = 32'h300;
    start_stream(32'h300);
    tick();
    write_eip = 1'b0;
    #1;
    vectors++;
    if (f_valid !== 1'b0 || f_pc !== 32'h300 || ic_req_valid !== 1'b1 || ic_req_addr !== 32'h300) begin
      miscompares++;
      $display("[TB] FAIL redirect_next: valid=%b pc=%h req=%b addr=%h expected 0 00000300 1 00000300",
               f_valid, f_pc, ic_req_valid, ic_req_addr);
    end
    tick();
    tick();
    #1;
    vectors++;
    if (ic_req_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL two_outstanding: req=%b expected 0", ic_req_valid);
    end
    write_eip = 1'b1;
    eip = 32'h20B;
    start_stream(32'h20B);
    tick();
    write_eip = 1'b0;
    #1;
    vectors++;
    if (f_valid !== 1'b0 || f_pc !== 32'h20B || ic_req_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL redirect_busy: valid=%b pc=%h req=%b expected 0 0000020b 0",
               f_valid, f_pc, ic_req_valid);
    end
    for (int i = 0; i < 10 && !ic_req_valid; i++) tick();
    vectors++;
    if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h200) begin
      miscompares++;
      $display("[TB] FAIL aligned_req: req=%b addr=%h expected 1 00000200", ic_req_valid, ic_req_addr);
    end
    for (int i = 0; i < 20 && !f_valid; i++) tick();
    vectors++;
    if (f_valid_bytes !== 6'd5 || f_pc !== 32'h20B || f_instruction[255:248] !== mem_byte(32'h20B)) begin
      miscompares++;
      $display("[TB] FAIL skip_line: n=%0d pc=%h b0=%h expected 5 0000020b %h",
               f_valid_bytes, f_pc, f_instruction[255:248], mem_byte(32'h20B));
    end
  endtask

  task automatic test_redirect_collision();
    for (int i = 0; i < 30 && !(ic_resp_valid && f_valid_bytes != 6'd0); i++) tick();
    vectors++;
    if (ic_resp_valid !== 1'b1 || f_valid_bytes == 6'd0) begin
      miscompares++;
      $display("[TB] FAIL collision_setup: resp=%b n=%0d expected 1 nonzero", ic_resp_valid, f_valid_bytes);
    end
    write_eip = 1'b1;
    eip = 32'h405;
    f_ready = 1'b1;
    f_bytes_read = 6'd1;
    start_stream(32'h405);
    tick();
    write_eip = 1'b0;
    f_ready = 1'b0;
    #1;
    vectors++;
    if (f_valid_bytes !== 6'd0 || f_valid !== 1'b0 || f_pc !== 32'h405 ||
        ic_req_valid !== 1'b1 || ic_req_addr !== 32'h400) begin
      miscompares++;
      $display("[TB] FAIL collision_next: n=%0d valid=%b pc=%h req=%b addr=%h expected 0 0 00000405 1 00000400",
               f_valid_bytes, f_valid, f_pc, ic_req_valid, ic_req_addr);
    end
    for (int i = 0; i < 20 && !f_valid; i++) tick();
    vectors++;
    if (f_valid_bytes !== 6'd11 || f_instruction[255:248] !== mem_byte(32'h405)) begin
      miscompares++;
      $display("[TB] FAIL collision_line: n=%0d b0=%h expected 11 %h",
               f_valid_bytes, f_instruction[255:248], mem_byte(32'h405));
    end
  endtask

  task automatic test_backpressure();
    int start_consumed;
    write_eip = 1'b1;
    eip = 32'h600;
    start_stream(32'h600);
    tick();
    write_eip = 1'b0;
    for (int i = 0; i < 60 && !(f_valid_bytes == 6'd32 && !ic_req_valid); i++) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (f_valid_bytes !== 6'd32 || ic_req_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL saturate: n=%0d req=%b expected 32 0", f_valid_bytes, ic_req_valid);
      end
    end
    start_consumed = consumed;
    for (int i = 0; i < 400; i++) begin
      ic_req_ready = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(1, 3);
      if (f_valid && $urandom_range(0, 1) == 1) begin
        f_ready = 1'b1;
        f_bytes_read = 6'($urandom_range(1, int'(f_valid_bytes)));
      end else begin
        f_ready = 1'b0;
        f_bytes_read = 6'd0;
      end
      tick();
    end
    f_ready = 1'b0;
    ic_req_ready = 1'b1;
    vectors++;
    if (consumed - start_consumed < 200) begin
      miscompares++;
      $display("[TB] FAIL stream_progress: consumed=%0d expected >=200", consumed - start_consumed);
    end
  endtask

  task automatic test_wrap();
    lat = 1;
    write_eip = 1'b1;
    eip = 32'hFFFF_FFF6;
    start_stream(32'hFFFF_FFF6);
    tick();
    write_eip = 1'b0;
    #1;
    for (int i = 0; i < 10 && !ic_req_valid; i++) tick();
    vectors++;
    if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'hFFFF_FFF0) begin
      miscompares++;
      $display("[TB] FAIL wrap_req0: req=%b addr=%h expected 1 fffffff0", ic_req_valid, ic_req_addr);
    end
    tick();
    for (int i = 0; i < 10 && !ic_req_valid; i++) tick();
    vectors++;
    if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL wrap_req1: req=%b addr=%h expected 1 00000000", ic_req_valid, ic_req_addr);
    end
    for (int i = 0; i < 20 && f_valid_bytes < 6'd26; i++) tick();
    f_ready = 1'b1;
    f_bytes_read = 6'd12;
    tick();
    f_ready = 1'b0;
    vectors++;
    if (f_pc !== 32'h2 || f_valid_bytes !== 6'd14) begin
      miscompares++;
      $display("[TB] FAIL wrap_pc: pc=%h n=%0d expected 00000002 14", f_pc, f_valid_bytes);
    end
  endtask

  task automatic test_reset_midstream();
    reset = 1'b0;
    start_stream(32'h100);
    #1;
    vectors++;
    if (f_valid !== 1'b0 || f_valid_bytes !== 6'd0 || f_instruction !== '0 ||
        ic_req_valid !== 1'b0 || f_branch_taken !== 1'b0 || f_pc !== 32'h100) begin
      miscompares++;
      $display("[TB] FAIL midstream_reset: valid=%b n=%0d req=%b pc=%h expected 0 0 0 00000100",
               f_valid, f_valid_bytes, ic_req_valid, f_pc);
    end
    tick();
    tick();
    reset = 1'b1;
    #1;
    vectors++;
    if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h100) begin
      miscompares++;
      $display("[TB] FAIL restart_req: req=%b addr=%h expected 1 00000100", ic_req_valid, ic_req_addr);
    end
    for (int i = 0; i < 10 && !f_valid; i++) tick();
    vectors++;
    if (f_valid_bytes !== 6'd16 || f_pc !== 32'h100 || f_instruction[255:248] !== mem_byte(32'h100)) begin
      miscompares++;
      $display("[TB] FAIL restart_line: n=%0d pc=%h b0=%h expected 16 00000100 %h",
               f_valid_bytes, f_pc, f_instruction[255:248], mem_byte(32'h100));
    end
  endtask

  initial begin
    reset = 1'b0;
    write_eip = 1'b0;
    eip = '0;
    ic_req_ready = 1'b1;
    ic_resp_valid = 1'b0;
    ic_resp_data = '0;
    f_ready = 1'b0;
    f_bytes_read = 6'd0;
    start_stream(32'h100);
    test_reset();
    test_consume();
    test_redirect_drop();
    test_redirect_collision();
    test_backpressure();
    test_wrap();
    test_reset_midstream();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
